// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the 20-bit XNOR Fibonacci dither/test LFSR stream.
// It self-synchronises to the incoming bits, declares lock after a run of
// correct predictions, then free-runs its own copy of the sequence so that
// every corrupted received bit produces exactly one error pulse.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   bit_i      received serial bit
//   valid_i    qualifies bit_i; no state advances while low
//   clear_i    synchronous clear of err_cnt_o and the window counters
//   locked_o   checker is locked to the sequence
//   err_o      one-cycle pulse per mismatching bit while locked
//   err_cnt_o  saturating count of errors seen while locked
module lfsr_checker #(
  parameter int WIDTH     = 20,
  parameter int TAP_A     = 19,
  parameter int TAP_B     = 16,
  parameter int LOCK_CNT  = 32,
  parameter int WINDOW    = 256,
  parameter int ERR_LIMIT = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bit_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic                locked_o,
  output logic                err_o,
  output logic [CNT_BITS-1:0] err_cnt_o
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(ERR_LIMIT);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    s_q, s_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [WERR_W-1:0]   werr_q, werr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic             predicted;
  logic             mismatch;
  logic [WIDTH-1:0] shifted;
  logic [WERR_W-1:0] werr_inc;

  assign predicted = s_q[TAP_A] ~^ s_q[TAP_B];
  assign mismatch  = bit_i ^ predicted;
  assign shifted   = {s_q[WIDTH-2:0], bit_i};
  assign werr_inc  = werr_q + {{(WERR_W-1){1'b0}}, mismatch};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (valid_i) begin
      case (state_q)
        HUNT: begin
          s_d = shifted;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            // All-ones is the XNOR lockup state; it cannot seed a valid
            // sequence, so keep hunting.
            if (!(&shifted)) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_ONE;
          end
        end

        VERIFY: begin
          s_d = shifted;
          if (!mismatch) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MATCH_ONE;
            end
          end else begin
            // The offending bit is already in s and counts as fill bit one.
            state_d = HUNT;
            fill_d  = FILL_ONE;
          end
        end

        LOCKED: begin
          // Free-run on the prediction so a corrupted bit never pollutes s.
          s_d   = {s_q[WIDTH-2:0], predicted};
          err_d = mismatch;
          if (mismatch && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_ONE;
          if (werr_inc >= WERR_LIM) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (win_q == WIN_LAST) begin
            werr_d = '0;
          end else begin
            werr_d = werr_inc;
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // Clear wins over any increment above but leaves lock state alone.
    if (clear_i) begin
      cnt_d  = '0;
      werr_d = '0;
      win_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule
